// File: rtl/four_bit_pair_serializer_pkg.sv
// Shared types and constants for the four-bit pair serializer.
// The state type, nibble width and parity helper live here so the block and its hold registers agree.
package four_bit_pair_serializer_pkg;

  localparam int NIB_W   = 4;
  localparam int NUM_NIB = 2;

  typedef logic [NIB_W-1:0] nib_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2
  } state_e;

  typedef struct packed {
    nib_t b;
    nib_t a;
  } pair_t;

  function automatic logic nib_parity(input nib_t n);
    return ^n;
  endfunction

endpackage

// File: rtl/four_bit_pair_serializer_if.sv
// Handshake and mux-drive bundle between the serializer and its environment.
// The slave side is the serializer; the master side is the producer/consumer around it.
interface four_bit_pair_serializer_if;
  import four_bit_pair_serializer_pkg::*;

  logic in_valid;
  logic in_ready;
  nib_t in_a;
  nib_t in_b;
  nib_t mux_a;
  nib_t mux_b;
  logic mux_s;
  logic out_valid;
  logic out_ready;
  logic out_last;
  nib_t pair_count;
  logic out_parity;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, mux_a, mux_b, mux_s, out_valid, out_last, pair_count, out_parity
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, mux_a, mux_b, mux_s, out_valid, out_last, pair_count, out_parity
  );

endinterface

// File: rtl/four_bit_pair_serializer_hold_reg.sv
// Four-bit hold register with load enable and synchronous active-low reset.
// One instance holds each nibble of the captured pair.
module four_bit_hold_reg
  import four_bit_pair_serializer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ld_i,
  input  nib_t d_i,
  output nib_t q_o
);

  nib_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld_i) q_d = d_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/four_bit_pair_serializer.sv
// Serializes a captured nibble pair onto an external 4-bit 2:1 mux (a first, then b), valid/ready both sides.
// Optional even parity of the selected nibble when SERIALIZER_PARITY_EN is defined; otherwise out_parity is 0.
module four_bit_pair_serializer
  import four_bit_pair_serializer_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  four_bit_pair_serializer_if.slave     bus
);

  state_e state_q, state_d;
  nib_t   cnt_q, cnt_d;
  logic   cap;
  logic   in_rdy;
  pair_t  pair_in;
  logic [NUM_NIB-1:0][NIB_W-1:0] hold_d, hold_q;

  assign pair_in   = '{b: bus.in_b, a: bus.in_a};
  assign hold_d[0] = pair_in.a;
  assign hold_d[1] = pair_in.b;

  // Accept in IDLE, or in SEND_B when the final nibble is leaving this cycle.
  assign in_rdy = rst_n && ((state_q == IDLE) || ((state_q == SEND_B) && bus.out_ready));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          cap     = 1'b1;
          state_d = SEND_A;
        end
      end
      SEND_A: begin
        if (bus.out_ready) state_d = SEND_B;
      end
      SEND_B: begin
        if (bus.out_ready) begin
          cnt_d = cnt_q + 4'd1;
          if (bus.in_valid) begin
            cap     = 1'b1;
            state_d = SEND_A;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_NIB; g++) begin : g_hold
    four_bit_hold_reg u_hold (
      .clk   (clk),
      .rst_n (rst_n),
      .ld_i  (cap),
      .d_i   (hold_d[g]),
      .q_o   (hold_q[g])
    );
  end

  assign bus.in_ready   = in_rdy;
  assign bus.mux_a      = hold_q[0];
  assign bus.mux_b      = hold_q[1];
  assign bus.mux_s      = (state_q == SEND_B);
  assign bus.out_valid  = (state_q == SEND_A) || (state_q == SEND_B);
  assign bus.out_last   = (state_q == SEND_B);
  assign bus.pair_count = cnt_q;

`ifdef SERIALIZER_PARITY_EN
  // Parity of each held nibble is formed separately; the select picks a bit, not a nibble.
  logic par_a, par_b;
  assign par_a          = nib_parity(hold_q[0]);
  assign par_b          = nib_parity(hold_q[1]);
  assign bus.out_parity = bus.out_valid && (bus.mux_s ? par_b : par_a);
`else
  assign bus.out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_four_bit_pair_serializer.sv
// Directed bench for four_bit_pair_serializer: reset, single pair, backpressure, back-to-back, wrap, parity.
// Build with SERIALIZER_PARITY_EN to exercise the parity path.
module tb_four_bit_pair_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  four_bit_pair_serializer_if bus ();

  four_bit_pair_serializer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic ep(input logic [3:0] n);
    return (^n) & PAR_EN;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected presentation on the external mux: valid, select, selected nibble, last, parity.
  task automatic chk_out(input string tag, input logic v, input logic s, input logic [3:0] nib);
    logic [3:0] sel;
    sel = bus.mux_s ? bus.mux_b : bus.mux_a;
    chk({tag, ".valid"}, bus.out_valid, v);
    chk({tag, ".s"},     bus.mux_s, s);
    chk({tag, ".last"},  bus.out_last, s);
    chk({tag, ".nib"},   sel, nib);
    chk({tag, ".par"},   bus.out_parity, v ? ep(nib) : 1'b0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;

    // Reset held two cycles with in_valid asserted
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a = 4'h5;
    bus.in_b = 4'hA;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst.in_ready", bus.in_ready, 1'b0);
      chk("rst.valid", bus.out_valid, 1'b0);
      chk("rst.last", bus.out_last, 1'b0);
      chk("rst.s", bus.mux_s, 1'b0);
      chk("rst.mux_a", bus.mux_a, 4'h0);
      chk("rst.mux_b", bus.mux_b, 4'h0);
      chk("rst.cnt", bus.pair_count, 4'h0);
      chk("rst.par", bus.out_parity, 1'b0);
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("idle.in_ready", bus.in_ready, 1'b1);

    // Single pair 0x3, 0xC
    bus.in_valid = 1'b1;
    bus.in_a = 4'h3;
    bus.in_b = 4'hC;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk_out("single.A", 1'b1, 1'b0, 4'h3);
    chk("single.A.in_ready", bus.in_ready, 1'b0);
    tick();
    chk_out("single.B", 1'b1, 1'b1, 4'hC);
    chk("single.B.in_ready", bus.in_ready, 1'b1);
    tick();
    chk("single.cnt", bus.pair_count, 4'd1);
    chk("single.idle.valid", bus.out_valid, 1'b0);

    // Backpressure in SEND_A; in_valid offered meanwhile must be ignored
    bus.in_valid = 1'b1;
    bus.in_a = 4'h3;
    bus.in_b = 4'h6;
    bus.out_ready = 1'b0;
    tick();
    bus.in_a = 4'hF;
    bus.in_b = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("bp.A", 1'b1, 1'b0, 4'h3);
      chk("bp.mux_a", bus.mux_a, 4'h3);
      chk("bp.mux_b", bus.mux_b, 4'h6);
      chk("bp.in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk_out("bp.B", 1'b1, 1'b1, 4'h6);
    tick();
    chk("bp.cnt", bus.pair_count, 4'd2);
    chk("bp.idle.valid", bus.out_valid, 1'b0);

    // Back-to-back pairs (1,2),(4,8)
    bus.in_valid = 1'b1;
    bus.in_a = 4'h1;
    bus.in_b = 4'h2;
    tick();
    bus.in_a = 4'h4;
    bus.in_b = 4'h8;
    #1;
    chk_out("b2b.1", 1'b1, 1'b0, 4'h1);
    chk("b2b.1.in_ready", bus.in_ready, 1'b0);
    tick();
    chk_out("b2b.2", 1'b1, 1'b1, 4'h2);
    chk("b2b.2.in_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk_out("b2b.4", 1'b1, 1'b0, 4'h4);
    chk("b2b.cnt3", bus.pair_count, 4'd3);
    tick();
    chk_out("b2b.8", 1'b1, 1'b1, 4'h8);
    chk("b2b.8.in_ready", bus.in_ready, 1'b1);
    tick();
    chk("b2b.cnt4", bus.pair_count, 4'd4);
    chk("b2b.idle.valid", bus.out_valid, 1'b0);

    // Parity-sensitive pair (7,3)
    bus.in_valid = 1'b1;
    bus.in_a = 4'h7;
    bus.in_b = 4'h3;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk_out("par.7", 1'b1, 1'b0, 4'h7);
    tick();
    chk_out("par.3", 1'b1, 1'b1, 4'h3);
    tick();
    chk("par.cnt", bus.pair_count, 4'd5);

    // Fresh reset, then reset asserted in SEND_B with out_ready high
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a = 4'h9;
    bus.in_b = 4'h5;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk_out("rstB.pre", 1'b1, 1'b1, 4'h5);
    rst_n = 1'b0;
    #1;
    chk("rstB.in_ready", bus.in_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rstB.cnt", bus.pair_count, 4'd0);
    chk("rstB.valid", bus.out_valid, 1'b0);
    chk("rstB.mux_b", bus.mux_b, 4'h0);
    chk("rstB.in_ready_idle", bus.in_ready, 1'b1);

    // Seventeen pairs from zero: count walks through 15, wraps to 0, then 1
    for (int k = 1; k <= 17; k++) begin
      bus.in_valid = 1'b1;
      bus.in_a = 4'(k);
      bus.in_b = 4'(~k);
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      chk($sformatf("wrap.cnt%0d", k), bus.pair_count, 32'(k % 16));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
